vx_commit_tracker: RTL and testbench

Per-warp tracker of in-flight instructions between issue and commit, sitting beside the warp scheduler.
- Counts instructions issued but not yet committed on each warp.
- Consumes the per-issue-slot commit strobes and warp IDs from the commit stage.
- Exports per-warp idle and near-full status to the scheduler.
- Runs a one-at-a-time drain sequencer used for fences, barriers and warp teardown.

---
 rtl/vx_commit_tracker_pkg.sv | 23 ++
 rtl/vx_commit_tracker_pending_ctr.sv | 48 ++++
 rtl/vx_commit_tracker.sv | 128 ++++++++++++
 tb/tb_vx_commit_tracker.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_commit_tracker_pkg.sv
// Shared types and helpers for the warp commit tracker.
// Drain sequencer states, counter width default, popcount.
package VX_gpu_pkg;

  localparam int CTR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_WAIT,
    DRAIN_DONE
  } drain_state_e;

  // Number of set bits in a per-warp slot match mask.
  function automatic logic [5:0] popcount(input logic [31:0] mask);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(mask[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/vx_commit_tracker_pending_ctr.sv
// Single-warp in-flight counter with saturation
// and sticky overflow/underflow flags.
module vx_warp_pending_ctr #(
  parameter int CTR_WIDTH = 8,
  parameter int INC_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic [INC_WIDTH-1:0] dec,
  output logic [CTR_WIDTH-1:0] cnt,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam int SW = CTR_WIDTH + 2;

  logic [SW-1:0]        sum;
  logic                 ovf;
  logic                 unf;
  logic [CTR_WIDTH-1:0] cnt_d;

  // MSB is the sign; bit CTR_WIDTH set on a positive sum means > MAX.
  always_comb begin
    sum   = SW'(cnt) + SW'(inc) - SW'(dec);
    unf   = sum[SW-1];
    ovf   = ~sum[SW-1] & sum[CTR_WIDTH];
    cnt_d = sum[CTR_WIDTH-1:0];
    if (unf) begin
      cnt_d = '0;
    end else if (ovf) begin
      cnt_d = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      cnt           <= cnt_d;
      err_overflow  <= err_overflow | ovf;
      err_underflow <= err_underflow | unf;
    end
  end

endmodule

// File: rtl/vx_commit_tracker.sv
// Per-warp issue/commit tracker with idle/full status
// and a single-request drain sequencer.
module vx_commit_tracker
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS = 8,
  parameter int ISSUE_CNT = 2,
  parameter int NW_WIDTH  = 3,
  parameter int CTR_WIDTH = CTR_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ISSUE_CNT-1:0]           issue_valid,
  input  logic [ISSUE_CNT*NW_WIDTH-1:0]  issue_wid,
  input  logic [ISSUE_CNT-1:0]           committed,
  input  logic [ISSUE_CNT*NW_WIDTH-1:0]  committed_wid,
  output logic [NUM_WARPS*CTR_WIDTH-1:0] pending_cnt,
  output logic [NUM_WARPS-1:0]           warp_idle,
  output logic [NUM_WARPS-1:0]           warp_full,
  input  logic                           drain_valid,
  input  logic [NW_WIDTH-1:0]            drain_wid,
  output logic                           drain_ready,
  output logic                           drain_done,
  output logic                           err_overflow,
  output logic                           err_underflow
);

  localparam int CW = $clog2(ISSUE_CNT + 1);
  localparam logic [CTR_WIDTH-1:0] FULL_TH =
    CTR_WIDTH'((1 << CTR_WIDTH) - 1 - ISSUE_CNT);

  logic [NUM_WARPS-1:0][ISSUE_CNT-1:0] inc_mask;
  logic [NUM_WARPS-1:0][ISSUE_CNT-1:0] dec_mask;
  logic [NUM_WARPS-1:0][CW-1:0]        inc;
  logic [NUM_WARPS-1:0][CW-1:0]        dec;
  logic [NUM_WARPS-1:0][CTR_WIDTH-1:0] cnt;
  logic [NUM_WARPS-1:0]                ovf;
  logic [NUM_WARPS-1:0]                unf;

  // Out-of-range warp IDs never match any w and so drop out here.
  always_comb begin
    inc_mask = '0;
    dec_mask = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int i = 0; i < ISSUE_CNT; i++) begin
        inc_mask[w][i] = issue_valid[i] &&
          (issue_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w));
        dec_mask[w][i] = committed[i] &&
          (committed_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w));
      end
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign inc[w] = CW'(popcount(32'(inc_mask[w])));
    assign dec[w] = CW'(popcount(32'(dec_mask[w])));

    vx_warp_pending_ctr #(
      .CTR_WIDTH (CTR_WIDTH),
      .INC_WIDTH (CW)
    ) u_ctr (
      .clk           (clk),
      .reset_n       (reset_n),
      .inc           (inc[w]),
      .dec           (dec[w]),
      .cnt           (cnt[w]),
      .err_overflow  (ovf[w]),
      .err_underflow (unf[w])
    );

    assign pending_cnt[w*CTR_WIDTH +: CTR_WIDTH] = cnt[w];
    assign warp_idle[w] = (cnt[w] == '0);
    assign warp_full[w] = (cnt[w] > FULL_TH);
  end

  assign err_overflow  = |ovf;
  assign err_underflow = |unf;

  drain_state_e         state_q;
  drain_state_e         state_d;
  logic [NW_WIDTH-1:0]  drain_wid_q;
  logic [CTR_WIDTH-1:0] drain_cnt;
  logic                 drain_inc;

  always_comb begin
    drain_cnt = '0;
    drain_inc = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (drain_wid_q == NW_WIDTH'(w)) begin
        drain_cnt = cnt[w];
        drain_inc = |inc[w];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= DRAIN_IDLE;
      drain_wid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DRAIN_IDLE && drain_valid) begin
        drain_wid_q <= drain_wid;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_ready = 1'b0;
    drain_done  = 1'b0;
    unique case (state_q)
      DRAIN_IDLE: begin
        drain_ready = 1'b1;
        if (drain_valid) state_d = DRAIN_WAIT;
      end
      DRAIN_WAIT: begin
        if (drain_cnt == '0 && !drain_inc) state_d = DRAIN_DONE;
      end
      DRAIN_DONE: begin
        drain_done = 1'b1;
        state_d    = DRAIN_IDLE;
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vx_commit_tracker.sv
// Directed bench for vx_commit_tracker.
// 8 warps, 2 slots, 4-bit wid (ids 8..15 out of range), 4-bit counters.
module tb_vx_commit_tracker;

  localparam int NW  = 8;
  localparam int IC  = 2;
  localparam int WW  = 4;
  localparam int CTW = 4;

  logic              clk;
  logic              reset_n;
  logic [IC-1:0]     issue_valid;
  logic [IC*WW-1:0]  issue_wid;
  logic [IC-1:0]     committed;
  logic [IC*WW-1:0]  committed_wid;
  logic [NW*CTW-1:0] pending_cnt;
  logic [NW-1:0]     warp_idle;
  logic [NW-1:0]     warp_full;
  logic              drain_valid;
  logic [WW-1:0]     drain_wid;
  logic              drain_ready;
  logic              drain_done;
  logic              err_overflow;
  logic              err_underflow;

  int checks = 0;
  int errors = 0;

  vx_commit_tracker #(
    .NUM_WARPS (NW),
    .ISSUE_CNT (IC),
    .NW_WIDTH  (WW),
    .CTR_WIDTH (CTW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .issue_valid   (issue_valid),
    .issue_wid     (issue_wid),
    .committed     (committed),
    .committed_wid (committed_wid),
    .pending_cnt   (pending_cnt),
    .warp_idle     (warp_idle),
    .warp_full     (warp_full),
    .drain_valid   (drain_valid),
    .drain_wid     (drain_wid),
    .drain_ready   (drain_ready),
    .drain_done    (drain_done),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CTW-1:0] cnt_of(input int w);
    return pending_cnt[w*CTW +: CTW];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_valid   = '0;
    issue_wid     = '0;
    committed     = '0;
    committed_wid = '0;
    drain_valid   = 1'b0;
    drain_wid     = '0;
  endtask

  task automatic iss(input logic [1:0] v, input int w0, input int w1);
    issue_valid = v;
    issue_wid   = {WW'(w1), WW'(w0)};
  endtask

  task automatic cmt(input logic [1:0] v, input int w0, input int w1);
    committed     = v;
    committed_wid = {WW'(w1), WW'(w0)};
  endtask

  task automatic do_reset();
    idle_in();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pending_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want 0", pending_cnt);
    end
    checks++;
    if (warp_idle !== 8'hff || warp_full !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle_full: idle %h full %h want ff 00",
               warp_idle, warp_full);
    end
    checks++;
    if (drain_ready !== 1'b1 || drain_done !== 1'b0 ||
        err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: rdy %b done %b ovf %b unf %b want 1 0 0 0",
               drain_ready, drain_done, err_overflow, err_underflow);
    end
    // build cnt[2]=5 then start a drain and reset under it
    iss(2'b11, 2, 2); cyc();
    cyc();
    iss(2'b01, 2, 0); cyc();
    idle_in();
    drain_valid = 1'b1; drain_wid = 4'd2; cyc();
    idle_in();
    checks++;
    if (cnt_of(2) !== 4'd5 || drain_ready !== 1'b0) begin
      errors++;
      $display("FAIL middrain_setup: cnt2 %0d rdy %b want 5 0",
               cnt_of(2), drain_ready);
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if (pending_cnt !== '0 || warp_idle !== 8'hff) begin
      errors++;
      $display("FAIL middrain_reset: cnt %h idle %h want 0 ff",
               pending_cnt, warp_idle);
    end
    checks++;
    if (drain_ready !== 1'b1 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL middrain_ctl: rdy %b done %b want 1 0",
               drain_ready, drain_done);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (drain_done !== 1'b0 || drain_ready !== 1'b1) begin
        errors++;
        $display("FAIL postreset_nodone: cyc %0d done %b rdy %b want 0 1",
                 k, drain_done, drain_ready);
      end
    end
  endtask

  task automatic test_multi_slot();
    do_reset();
    iss(2'b11, 1, 1);
    for (int k = 0; k < 3; k++) cyc();
    idle_in();
    checks++;
    if (cnt_of(1) !== 4'd6 || warp_idle[1] !== 1'b0) begin
      errors++;
      $display("FAIL multi_inc: cnt1 %0d idle %b want 6 0",
               cnt_of(1), warp_idle[1]);
    end
    cmt(2'b11, 1, 1);
    cyc();
    checks++;
    if (cnt_of(1) !== 4'd4) begin
      errors++;
      $display("FAIL multi_dec1: cnt1 %0d want 4", cnt_of(1));
    end
    cyc();
    cyc();
    idle_in();
    checks++;
    if (cnt_of(1) !== 4'd0 || warp_idle[1] !== 1'b1) begin
      errors++;
      $display("FAIL multi_dec: cnt1 %0d idle %b want 0 1",
               cnt_of(1), warp_idle[1]);
    end
  endtask

  task automatic test_same_cycle_net();
    do_reset();
    iss(2'b11, 0, 0); cyc();
    iss(2'b01, 0, 0); cyc();
    idle_in();
    checks++;
    if (cnt_of(0) !== 4'd3) begin
      errors++;
      $display("FAIL net_setup: cnt0 %0d want 3", cnt_of(0));
    end
    iss(2'b11, 0, 0);
    cmt(2'b01, 0, 0);
    cyc();
    idle_in();
    checks++;
    if (cnt_of(0) !== 4'd4 || err_overflow !== 1'b0 ||
        err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL net_value: cnt0 %0d ovf %b unf %b want 4 0 0",
               cnt_of(0), err_overflow, err_underflow);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    iss(2'b11, 3, 3);
    for (int k = 0; k < 6; k++) cyc();
    checks++;
    if (cnt_of(3) !== 4'd12 || warp_full[3] !== 1'b0) begin
      errors++;
      $display("FAIL sat_12: cnt3 %0d full %b want 12 0",
               cnt_of(3), warp_full[3]);
    end
    cyc();
    checks++;
    if (cnt_of(3) !== 4'd14 || warp_full[3] !== 1'b1 ||
        err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_14: cnt3 %0d full %b ovf %b want 14 1 0",
               cnt_of(3), warp_full[3], err_overflow);
    end
    cyc();
    idle_in();
    checks++;
    if (cnt_of(3) !== 4'd15 || err_overflow !== 1'b1 ||
        err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_ovf: cnt3 %0d ovf %b unf %b want 15 1 0",
               cnt_of(3), err_overflow, err_underflow);
    end
    cmt(2'b01, 4, 0);
    cyc();
    idle_in();
    checks++;
    if (cnt_of(4) !== 4'd0 || err_underflow !== 1'b1 ||
        cnt_of(3) !== 4'd15) begin
      errors++;
      $display("FAIL sat_unf: cnt4 %0d unf %b cnt3 %0d want 0 1 15",
               cnt_of(4), err_underflow, cnt_of(3));
    end
    cyc();
    checks++;
    if (err_overflow !== 1'b1 || err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky: ovf %b unf %b want 1 1",
               err_overflow, err_underflow);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    iss(2'b11, 8, 15);
    cmt(2'b11, 9, 12);
    cyc();
    idle_in();
    checks++;
    if (pending_cnt !== '0 || err_underflow !== 1'b0 ||
        err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL oor_ignored: cnt %h unf %b ovf %b want 0 0 0",
               pending_cnt, err_underflow, err_overflow);
    end
  endtask

  task automatic test_drain();
    do_reset();
    iss(2'b11, 5, 5); cyc();
    idle_in();
    drain_valid = 1'b1; drain_wid = 4'd5; cyc();
    idle_in();
    checks++;
    if (drain_ready !== 1'b0 || drain_done !== 1'b0 ||
        cnt_of(5) !== 4'd2) begin
      errors++;
      $display("FAIL drain_accept: rdy %b done %b cnt5 %0d want 0 0 2",
               drain_ready, drain_done, cnt_of(5));
    end
    iss(2'b01, 5, 0);
    drain_valid = 1'b1; drain_wid = 4'd6;
    cyc();
    idle_in();
    checks++;
    if (cnt_of(5) !== 4'd3 || drain_ready !== 1'b0 ||
        drain_done !== 1'b0) begin
      errors++;
      $display("FAIL drain_issue: cnt5 %0d rdy %b done %b want 3 0 0",
               cnt_of(5), drain_ready, drain_done);
    end
    cmt(2'b11, 5, 5); cyc();
    cmt(2'b01, 5, 0); cyc();
    idle_in();
    checks++;
    if (cnt_of(5) !== 4'd0 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL drain_zero: cnt5 %0d done %b want 0 0",
               cnt_of(5), drain_done);
    end
    cyc();
    checks++;
    if (drain_done !== 1'b1 || drain_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: done %b rdy %b want 1 0",
               drain_done, drain_ready);
    end
    cyc();
    checks++;
    if (drain_done !== 1'b0 || drain_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: done %b rdy %b want 0 1",
               drain_done, drain_ready);
    end
    cyc();
    checks++;
    if (drain_done !== 1'b0 || drain_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_second_ignored: done %b rdy %b want 0 1",
               drain_done, drain_ready);
    end
  endtask

  task automatic test_idle_drain();
    do_reset();
    drain_valid = 1'b1; drain_wid = 4'd7; cyc();
    idle_in();
    checks++;
    if (drain_ready !== 1'b0 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_drain_wait: rdy %b done %b want 0 0",
               drain_ready, drain_done);
    end
    cyc();
    checks++;
    if (drain_done !== 1'b1 || drain_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_drain_done: done %b rdy %b want 1 0",
               drain_done, drain_ready);
    end
    cyc();
    checks++;
    if (drain_done !== 1'b0 || drain_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_drain_ret: done %b rdy %b want 0 1",
               drain_done, drain_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drain_valid = 1'b1; drain_wid = 4'd0; cyc();
    cyc();
    cyc();
    checks++;
    if (drain_ready !== 1'b1 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ret: rdy %b done %b want 1 0",
               drain_ready, drain_done);
    end
    drain_wid = 4'd1;
    iss(2'b01, 1, 0);
    cyc();
    idle_in();
    checks++;
    if (drain_ready !== 1'b0 || cnt_of(1) !== 4'd1) begin
      errors++;
      $display("FAIL b2b_accept2: rdy %b cnt1 %0d want 0 1",
               drain_ready, cnt_of(1));
    end
    cmt(2'b10, 0, 1); cyc();
    idle_in();
    cyc();
    checks++;
    if (drain_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done2: done %b want 1", drain_done);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    idle_in();
    test_reset();
    test_multi_slot();
    test_same_cycle_net();
    test_saturation();
    test_out_of_range();
    test_drain();
    test_idle_drain();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
